store_align_unit: RTL and testbench

- Store-path alignment unit between the execute stage and the data/instruction memories.
- Takes one store request per handshake (size, byte address, raw data) and produces word-aligned memory beats with byte-write masks and lane-shifted data.
- Misaligned stores that straddle a word boundary are split into two consecutive beats.
- Memory region decode steers each beat's mask to dmem, imem, or both.

---
 rtl/store_pkg.sv | 30 +++
 rtl/store_align_unit_if.sv | 36 +++
 rtl/store_lane_shift.sv | 38 +++
 rtl/store_align_unit.sv | 143 ++++++++++++++
 tb/tb_store_align_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/store_pkg.sv
// Shared encodings for the store alignment path: access sizes, memory regions
// and FSM states, plus region-hit helpers.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  localparam logic [3:0] REG_DMEM = 4'b0001;
  localparam logic [3:0] REG_IMEM = 4'b0010;
  localparam logic [3:0] REG_BOTH = 4'b0011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

  function automatic logic hits_dmem(input logic [3:0] region);
    return (region == REG_DMEM) || (region == REG_BOTH);
  endfunction

  function automatic logic hits_imem(input logic [3:0] region);
    return (region == REG_IMEM) || (region == REG_BOTH);
  endfunction

endpackage

// File: rtl/store_align_unit_if.sv
// Request and memory-beat signals of the store alignment unit.
// The master modport is the execute/memory side; the slave modport is the unit.
interface store_align_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [NB-1:0]     dmem_we;
  logic [NB-1:0]     imem_we;
  logic              mem_last;
  logic              err_pulse;

  modport master (
    output req_valid, req_size, req_addr, req_data, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_data, dmem_we, imem_we,
           mem_last, err_pulse
  );

  modport slave (
    input  req_valid, req_size, req_addr, req_data, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_data, dmem_we, imem_we,
           mem_last, err_pulse
  );

endinterface

// File: rtl/store_lane_shift.sv
// Combinational byte-lane generator: places a right-justified store of 2**size
// bytes at byte offset off inside a two-word window (mask and data).
module store_lane_shift #(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic [OFF_W-1:0]    off,
  input  logic [1:0]          size,
  input  logic [DATA_W-1:0]   data,
  output logic [2*NB-1:0]     wide_mask,
  output logic [2*DATA_W-1:0] wide_data,
  output logic                split,
  output logic                legal
);

  localparam int CNT_W = OFF_W + 4;

  logic [CNT_W-1:0]  nbytes;
  logic [NB-1:0]     lane_en;
  logic [DATA_W-1:0] data_kept;

  always_comb begin
    nbytes    = CNT_W'(1) << size;
    lane_en   = '0;
    data_kept = '0;
    // Bytes above the access size are dropped so stale upper data never leaks into a lane.
    for (int b = 0; b < NB; b++) begin
      lane_en[b]          = (CNT_W'(b) < nbytes);
      data_kept[8*b +: 8] = lane_en[b] ? data[8*b +: 8] : 8'h00;
    end
    wide_mask = {{NB{1'b0}}, lane_en} << off;
    wide_data = {{DATA_W{1'b0}}, data_kept} << {off, 3'b000};
    split     = (CNT_W'(off) + nbytes) > CNT_W'(NB);
    legal     = nbytes <= CNT_W'(NB);
  end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: turns one store request into one or two word-aligned
// memory beats with per-region byte-write masks.
//
// state | meaning
// IDLE  | no beat pending, request port open
// BEAT0 | first (or only) beat presented on the memory port
// BEAT1 | second beat of a word-straddling store presented
module store_align_unit
  import store_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 32,
  parameter int REGION_MSB       = 31,
  parameter int ALLOW_MISALIGNED = 1
) (
  input logic               clk,
  input logic               rst,
  store_align_unit_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  state_e            state;
  logic              valid_q;
  logic              last_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [NB-1:0]     dmem_q;
  logic [NB-1:0]     imem_q;

  logic [ADDR_W-1:0] b1_addr;
  logic [DATA_W-1:0] b1_data;
  logic [NB-1:0]     b1_dmem;
  logic [NB-1:0]     b1_imem;

  logic [OFF_W-1:0]    off;
  logic [ADDR_W-1:0]   base;
  logic [ADDR_W-1:0]   base_next;
  logic [2*NB-1:0]     wide_mask;
  logic [2*DATA_W-1:0] wide_data;
  logic                split;
  logic                legal;
  logic [3:0]          region0;
  logic [3:0]          region1;
  logic [NB-1:0]       b0_dmem_n;
  logic [NB-1:0]       b0_imem_n;
  logic [NB-1:0]       b1_dmem_n;
  logic [NB-1:0]       b1_imem_n;
  logic                accept;
  logic                beat_done;

  assign off       = bus.req_addr[OFF_W-1:0];
  assign base      = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign base_next = base + ADDR_W'(NB);

  store_lane_shift #(.DATA_W(DATA_W)) u_lane_shift (
    .off       (off),
    .size      (bus.req_size),
    .data      (bus.req_data),
    .wide_mask (wide_mask),
    .wide_data (wide_data),
    .split     (split),
    .legal     (legal)
  );

  // Each beat is decoded on its own address; the second beat may cross into another region.
  always_comb begin
    region0   = base[REGION_MSB -: 4];
    region1   = base_next[REGION_MSB -: 4];
    b0_dmem_n = hits_dmem(region0) ? wide_mask[NB-1:0]    : '0;
    b0_imem_n = hits_imem(region0) ? wide_mask[NB-1:0]    : '0;
    b1_dmem_n = hits_dmem(region1) ? wide_mask[2*NB-1:NB] : '0;
    b1_imem_n = hits_imem(region1) ? wide_mask[2*NB-1:NB] : '0;
  end

  assign beat_done     = valid_q && bus.mem_ready;
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.req_ready = (state == IDLE) || (beat_done && last_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      dmem_q  <= '0;
      imem_q  <= '0;
      b1_addr <= '0;
      b1_data <= '0;
      b1_dmem <= '0;
      b1_imem <= '0;
    end else begin
      err_q <= 1'b0;
      if (beat_done) begin
        if (!last_q) begin
          state  <= BEAT1;
          addr_q <= b1_addr;
          data_q <= b1_data;
          dmem_q <= b1_dmem;
          imem_q <= b1_imem;
          last_q <= 1'b1;
        end else begin
          state   <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          dmem_q  <= '0;
          imem_q  <= '0;
        end
      end
      // A new request overrides the retire above, giving one aligned store per cycle.
      if (accept) begin
        if (!legal || (split && (ALLOW_MISALIGNED == 0))) begin
          err_q <= 1'b1;
        end else begin
          state   <= BEAT0;
          valid_q <= 1'b1;
          last_q  <= !split;
          addr_q  <= base;
          data_q  <= wide_data[DATA_W-1:0];
          dmem_q  <= b0_dmem_n;
          imem_q  <= b0_imem_n;
          b1_addr <= base_next;
          b1_data <= wide_data[2*DATA_W-1:DATA_W];
          b1_dmem <= b1_dmem_n;
          b1_imem <= b1_imem_n;
        end
      end
    end
  end

  assign bus.mem_valid = valid_q;
  assign bus.mem_last  = last_q;
  assign bus.err_pulse = err_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_data  = data_q;
  assign bus.dmem_we   = dmem_q;
  assign bus.imem_we   = imem_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Scoreboard bench for store_align_unit: directed stores push expected beats,
// a negedge monitor pops and compares each accepted beat.
module tb_store_align_unit;
  import store_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  store_align_unit_if #(.DATA_W(32), .ADDR_W(32)) ia ();
  store_align_unit_if #(.DATA_W(32), .ADDR_W(32)) ib ();

  store_align_unit #(.DATA_W(32), .ADDR_W(32), .REGION_MSB(31), .ALLOW_MISALIGNED(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ia.slave)
  );
  store_align_unit #(.DATA_W(32), .ADDR_W(32), .REGION_MSB(31), .ALLOW_MISALIGNED(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ib.slave)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  dm;
    logic [3:0]  im;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    beat_cyc[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    err_seen_a = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void push_beat(input logic [31:0] addr, input logic [31:0] data,
                                    input logic [3:0] dm, input logic [3:0] im, input logic last);
    beat_t b;
    b.addr = addr; b.data = data; b.dm = dm; b.im = im; b.last = last;
    exp_q.push_back(b);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (!ia.mem_valid) check("mask_while_idle", {ia.dmem_we, ia.imem_we}, 64'h0);
      if (ia.mem_valid && ia.mem_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_beat: addr 0x%0h, none expected", ia.mem_addr);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_addr", ia.mem_addr, e.addr);
          check("beat_data", ia.mem_data, e.data);
          check("beat_dmem_we", ia.dmem_we, e.dm);
          check("beat_imem_we", ia.imem_we, e.im);
          check("beat_last", ia.mem_last, e.last);
          beat_cyc.push_back(cyc);
        end
      end
      if (ia.err_pulse) err_seen_a++;
      if (ib.mem_valid) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_beat_b: addr 0x%0h, none expected", ib.mem_addr);
      end
    end
  end

  task automatic send(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    int t = 0;
    ia.req_valid = 1'b1; ia.req_size = size; ia.req_addr = addr; ia.req_data = data;
    @(negedge clk);
    while (!ia.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ia.req_ready) begin
      n_vec++; n_err++;
      $display("FAIL req_timeout: req_ready 0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1 ia.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ia.req_valid = 0; ia.req_size = 0; ia.req_addr = 0; ia.req_data = 0; ia.mem_ready = 1;
    ib.req_valid = 0; ib.req_size = 0; ib.req_addr = 0; ib.req_data = 0; ib.mem_ready = 1;
    repeat (2) @(negedge clk);
    check("rst_mem_valid", ia.mem_valid, 0);
    check("rst_err_pulse", ia.err_pulse, 0);
    check("rst_mem_addr", ia.mem_addr, 0);
    check("rst_mem_data", ia.mem_data, 0);
    check("rst_masks", {ia.dmem_we, ia.imem_we}, 0);
    check("rst_req_ready", ia.req_ready, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    push_beat(32'h1000_0004, 32'hDEAD_BEEF, 4'b1111, 4'b0000, 1'b1);
    send(2'd2, 32'h1000_0004, 32'hDEAD_BEEF);
    push_beat(32'h3000_0000, 32'hAB00_0000, 4'b1000, 4'b1000, 1'b1);
    send(2'd0, 32'h3000_0003, 32'h0000_00AB);
    push_beat(32'h2000_0000, 32'h0000_C300, 4'b0000, 4'b0010, 1'b1);
    send(2'd0, 32'h2000_0001, 32'h5555_55C3);
    push_beat(32'h1000_0000, 32'h3400_0000, 4'b1000, 4'b0000, 1'b0);
    push_beat(32'h1000_0004, 32'h0000_0012, 4'b0001, 4'b0000, 1'b1);
    send(2'd1, 32'h1000_0003, 32'h0000_1234);
    push_beat(32'h1FFF_FFFC, 32'hCCDD_0000, 4'b1100, 4'b0000, 1'b0);
    push_beat(32'h2000_0000, 32'h0000_AABB, 4'b0000, 4'b0011, 1'b1);
    send(2'd2, 32'h1FFF_FFFE, 32'hAABB_CCDD);
    push_beat(32'hFFFF_FFFC, 32'h7600_0000, 4'b0000, 4'b0000, 1'b0);
    push_beat(32'h0000_0000, 32'h0000_0098, 4'b0000, 4'b0000, 1'b1);
    send(2'd1, 32'hFFFF_FFFF, 32'h0000_9876);
    push_beat(32'h3000_0004, 32'hBEEF_0000, 4'b1100, 4'b1100, 1'b1);
    send(2'd1, 32'h3000_0006, 32'hFFFF_BEEF);
    drain();

    // Backpressure: beat held for three cycles.
    ia.mem_ready = 1'b0;
    push_beat(32'h2000_0008, 32'h0102_0304, 4'b0000, 4'b1111, 1'b1);
    send(2'd2, 32'h2000_0008, 32'h0102_0304);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", ia.mem_valid, 1);
      check("stall_addr", ia.mem_addr, 32'h2000_0008);
      check("stall_data", ia.mem_data, 32'h0102_0304);
      check("stall_imem_we", ia.imem_we, 4'b1111);
      check("stall_req_ready", ia.req_ready, 0);
    end
    @(posedge clk); #1 ia.mem_ready = 1'b1;
    drain();

    // Back-to-back aligned words.
    beat_cyc.delete();
    push_beat(32'h1000_0010, 32'h1111_1111, 4'b1111, 4'b0000, 1'b1);
    push_beat(32'h1000_0014, 32'h2222_2222, 4'b1111, 4'b0000, 1'b1);
    send(2'd2, 32'h1000_0010, 32'h1111_1111);
    send(2'd2, 32'h1000_0014, 32'h2222_2222);
    drain();
    check("b2b_beats", beat_cyc.size(), 2);
    if (beat_cyc.size() == 2) check("b2b_gap", beat_cyc[1] - beat_cyc[0], 1);

    // Illegal size.
    send(2'd3, 32'h1000_0000, 32'h0000_0001);
    @(negedge clk);
    check("size3_err", ia.err_pulse, 1);
    check("size3_valid", ia.mem_valid, 0);
    @(negedge clk);
    check("size3_err_end", ia.err_pulse, 0);
    check("size3_valid_end", ia.mem_valid, 0);

    // Split word on the unit that rejects misaligned stores.
    @(posedge clk); #1;
    ib.req_valid = 1'b1; ib.req_size = 2'd2; ib.req_addr = 32'h1000_0002; ib.req_data = 32'hCAFE_F00D;
    @(negedge clk);
    check("b_req_ready", ib.req_ready, 1);
    @(posedge clk); #1 ib.req_valid = 1'b0;
    @(negedge clk);
    check("mis_err", ib.err_pulse, 1);
    check("mis_valid", ib.mem_valid, 0);
    @(negedge clk);
    check("mis_err_end", ib.err_pulse, 0);
    check("mis_valid_end", ib.mem_valid, 0);

    // Reset while the first beat of a split store is stalled.
    @(posedge clk); #1 ia.mem_ready = 1'b0;
    send(2'd1, 32'h1000_0003, 32'h0000_1234);
    @(negedge clk);
    check("split_stall_valid", ia.mem_valid, 1);
    check("split_stall_last", ia.mem_last, 0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", ia.mem_valid, 0);
    check("async_rst_masks", {ia.dmem_we, ia.imem_we}, 0);
    check("async_rst_addr", ia.mem_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 ia.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_valid", ia.mem_valid, 0);
      check("post_rst_ready", ia.req_ready, 1);
    end

    check("err_count_a", err_seen_a, 1);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
